// File: rtl/dmem_if.sv
// Request/response bundle between a load/store requester and a data-memory responder.
// Two independent valid/ready channels; a transfer happens on any rising edge where valid && ready.
interface dmem_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  // Valid/ready: the source raises valid and holds all payload stable until it
  // samples ready high on a rising edge; that edge is the transfer.
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [ADDRESS_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_be;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with WAIT_CYCLES wait states and one outstanding transaction.
// Optional macro DMEM_MISALIGN_ERR_EN: misaligned requests do no access and return rsp_err=1.
module dmem_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_WORDS     = 256,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      bus,
  output logic       busy,
  output logic [1:0] dbg_state
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    mis_q, mis_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           be_q, be_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_wword;
  logic                    req_mis;

  // Only the word index (and, with the error check, the low two bits) matter.
  logic unused_addr;
  assign unused_addr = ^bus.req_addr;

`ifdef DMEM_MISALIGN_ERR_EN
  assign req_mis = |bus.req_addr[1:0];
`else
  assign req_mis = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    mis_d     = mis_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_wword = mem_q[idx_q];
    for (int i = 0; i < NB; i++) begin
      if (be_q[i]) mem_wword[8*i +: 8] = wdata_q[8*i +: 8];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          idx_d   = bus.req_addr[IDX_W+1:2];
          mis_d   = req_mis;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // The access commits on this edge; rdata/err are frozen until the handshake.
          state_d = S_RESP;
          err_d   = mis_q;
          if (mis_q || we_q) begin
            rdata_d = '0;
            mem_we  = !mis_q && we_q && (|be_q);
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; writes are gated by state, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= mem_wword;
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written stall/reset sequences,
// and random traffic checked against a word-array model. Honours DMEM_MISALIGN_ERR_EN.
module tb_dmem_responder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 256;
  localparam int WC = 2;

`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [1:0] dbg_state;

  dmem_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmem_responder #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW), .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];        // {rsp_err, rsp_rdata}
  logic [31:0] mem_m [MW];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // Memory behaviour from the rules: word index wraps, stores merge enabled bytes,
  // misaligned requests (when enabled) leave memory alone and flag an error.
  function automatic logic [32:0] model_access(input logic we, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [3:0] be);
    int idx;
    idx = (addr / 4) % MW;
    if (MIS_EN && (addr % 4 != 0)) return {1'b1, 32'h0};
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
      return 33'h0;
    end
    return {1'b0, mem_m[idx]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the response handshake.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int stall, input string tag);
    int lat;
    logic [32:0] exp;
    exp = exp_q.pop_front();
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_be = be;
    lat = 0;
    while (!bus.req_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    check({tag, " req_ready before accept"}, bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check({tag, " busy after accept"}, busy, 1);
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check({tag, " latency"}, lat, WC + 1);
    if (!bus.rsp_valid) return;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, " stall rsp_valid"}, bus.rsp_valid, 1);
      check({tag, " stall rdata"}, bus.rsp_rdata, exp[31:0]);
    end
    check({tag, " rdata"}, bus.rsp_rdata, exp[31:0]);
    check({tag, " err"}, bus.rsp_err, exp[32]);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, " req_ready after rsp"}, bus.req_ready, 1);
    check({tag, " rsp_valid after rsp"}, bus.rsp_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, bus.req_ready, 1);
    check({tag, " rsp_valid"}, bus.rsp_valid, 0);
    check({tag, " rsp_rdata"}, bus.rsp_rdata, 0);
    check({tag, " rsp_err"}, bus.rsp_err, 0);
    check({tag, " busy"}, busy, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [32:0] r;
    logic [31:0] old;
    int lat;
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0; bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Give every word a known value so later loads have defined expectations.
    for (int i = 0; i < MW; i++) begin
      wdata = $urandom;
      exp_q.push_back(model_access(1'b1, i * 4, wdata, 4'hF));
      do_txn(1'b1, i * 4, wdata, 4'hF, 0, "init");
    end

    // Directed vector table.
    vecs.push_back(mk(1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 0));
    vecs.push_back(mk(0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h20,  32'h11223344, 4'hF, 32'h0, 0));
    vecs.push_back(mk(1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0, 0));
    vecs.push_back(mk(0, 32'h20,  32'h0,        4'hF, 32'h11BB33DD, 0));
    vecs.push_back(mk(1, 32'h4,   32'hCAFEF00D, 4'hF, 32'h0, 0));
    vecs.push_back(mk(0, 32'h4 + MW * 4, 32'h0, 4'h0, 32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 32'h40,  32'h55667788, 4'hF, 32'h0, 0));
    vecs.push_back(mk(1, 32'h42,  32'h01020304, 4'hF, 32'h0, MIS_EN));
    vecs.push_back(mk(0, 32'h40,  32'h0,        4'h0, MIS_EN ? 32'h55667788 : 32'h01020304, 0));
    vecs.push_back(mk(1, 32'h60,  32'hFFFFFFFF, 4'hF, 32'h0, 0));
    vecs.push_back(mk(1, 32'h60,  32'h0,        4'h0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h60,  32'h0,        4'h0, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(0, 32'h61,  32'h0,        4'h0, MIS_EN ? 32'h0 : 32'hFFFFFFFF, MIS_EN));
    for (int i = 0; i < vecs.size(); i++) begin
      r = model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, i % 3, $sformatf("vec%0d", i));
    end

    // Response stall with a second request waiting.
    exp_q.push_back(model_access(1'b1, 32'h50, 32'h5A5A1234, 4'hF));
    do_txn(1'b1, 32'h50, 32'h5A5A1234, 4'hF, 0, "stall_setup");
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h50; bus.req_be = 4'h0;
    @(posedge clk); #1;
    bus.req_addr = 32'h10;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("stall first latency", lat, WC + 1);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      check("stall rsp_valid", bus.rsp_valid, 1);
      check("stall rsp_rdata", bus.rsp_rdata, 32'h5A5A1234);
      check("stall req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("stall no accept at handshake", busy, 0);
    check("stall req_ready after handshake", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("stall second accept", busy, 1);
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("stall second latency", lat, WC + 1);
    check("stall second rdata", bus.rsp_rdata, mem_m[(32'h10 / 4) % MW]);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    // Reset during WAIT discards the store.
    old = mem_m[(32'h30 / 4) % MW];
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h30;
    bus.req_wdata = 32'h12345678; bus.req_be = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rst_wait busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait async");
    @(posedge clk); #1;
    check_reset_outputs("rst_wait held");
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, old});
    do_txn(1'b0, 32'h30, 32'h0, 4'h0, 0, "rst_wait load");

    // Reset during RESP drops the response but keeps the committed store.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h34;
    bus.req_wdata = 32'h0BADCAFE; bus.req_be = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("rst_resp latency", lat, WC + 1);
    r = model_access(1'b1, 32'h34, 32'h0BADCAFE, 4'hF);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_resp async");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 32'h0BADCAFE});
    do_txn(1'b0, 32'h34, 32'h0, 4'h0, 0, "rst_resp load");

    // Random traffic against the model.
    for (int i = 0; i < 200; i++) begin
      we    = 1'($urandom_range(0, 1));
      addr  = $urandom_range(0, MW * 8 - 1);
      wdata = $urandom;
      be    = 4'($urandom_range(0, 15));
      exp_q.push_back(model_access(we, addr, wdata, be));
      do_txn(we, addr, wdata, be, $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core's load/store port, i.e. the target end of the data-memory request interface driven by the CPU datapath. It accepts one word-addressed request at a time over a valid/ready handshake. It models a configurable number of wait states, performs the read or byte-masked write into an internal word array, and returns a response over a second valid/ready handshake. It replaces the zero-latency data memory so the core and later pipeline work can be exercised against a memory with real latency.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, request address width in bits
- DATA_WIDTH, 32, data word width; must be a multiple of 8
- MEM_WORDS, 256, number of words in the array; power of two
- WAIT_CYCLES, 2, wait states inserted before the access (0 allowed)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDRESS_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data
- req_be  in  DATA_WIDTH/8  store byte enables; bit i covers bits [8i+7:8i]
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  DATA_WIDTH  load data; 0 for stores
- rsp_err  out  1  misaligned-access flag (see Configuration)
- busy  out  1  high in WAIT or RESP

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, capture we/addr/wdata/be, load cnt = WAIT_CYCLES, go to WAIT.
- WAIT:
  - req_ready = 0.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: perform the access, go to RESP.
- Access:
  - Index = addr[$clog2(MEM_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo MEM_WORDS*4.
  - Store: write only enabled byte lanes. Other lanes keep their value. rsp_rdata is registered as 0.
  - Load: rsp_rdata is registered with the full word. req_be is ignored.
  - be = 0 on a store: no array change; the response is still returned.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err stay stable until the handshake.
  - On rsp_valid && rsp_ready, go to IDLE.
  - rsp_ready held low stalls indefinitely. Requests are not accepted while stalled.
- One outstanding transaction only. Requests arriving outside IDLE are not accepted; the requester must hold them.
- Reset values:
  - state = IDLE, cnt = 0.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - Array contents are not reset.
- Reset mid-operation:
  - An uncommitted store (still in WAIT) is discarded.
  - A store already committed persists.
  - The pending response is dropped.

## Timing
- Accept edge E0.
- The access is committed at edge E0+WAIT_CYCLES+1.
- rsp_valid is high from edge E0+WAIT_CYCLES+1 onward.
- Minimum transaction latency: WAIT_CYCLES+1 cycles from accept to rsp_valid.
- If the response is accepted at edge E1, req_ready is high after E1. The next accept is at E1+1 at the earliest, so throughput is at most one transaction per WAIT_CYCLES+3 cycles.
- A load issued directly after a store to the same word returns the new data.
- req_ready is a registered function of state only. It has no combinational path from req_valid.

## Configuration
- DMEM_MISALIGN_ERR_EN defined:
  - A request with addr[1:0] != 0 follows the same FSM and latency.
  - No array write occurs, rsp_rdata = 0, and rsp_err = 1 with the response.
  - Aligned requests return rsp_err = 0.
- Not defined:
  - addr[1:0] is ignored; the access proceeds on the aligned word.
  - rsp_err is tied to 0.

## Test plan
- Reset, then a store with WAIT_CYCLES=2, addr 0x10, wdata 0xDEADBEEF, be 0xF, followed by a load of 0x10 -> rsp_valid 3 cycles after each accept; load returns 0xDEADBEEF; store returns rdata 0.
- Store 0x11223344 to 0x20, then store 0xAABBCCDD to 0x20 with be 0x5, then load 0x20 -> returns 0x11BB33DD.
- Store 0xCAFEF00D to 0x4, then load 0x4 + MEM_WORDS*4 -> returns 0xCAFEF00D (wrap-around).
- Response stall: hold rsp_ready low for 5 cycles with req_valid high -> rsp_valid and rsp_rdata stay stable, req_ready stays 0, and no second accept occurs until one cycle after the handshake.
- Assert rst during WAIT of a store of 0x12345678 to 0x30, then load 0x30 -> old contents returned; all outputs read their reset values while rst is high.
- With DMEM_MISALIGN_ERR_EN: store to 0x42 -> rsp_err 1 and the word at 0x40 is unchanged. Without the macro: the same store writes the word at 0x40 and rsp_err is 0.
